// File: rtl/posit_result_wb.sv
// ---------------------------------------------------------------------------
// posit_result_wb
//
// Writeback buffer that sits after the posit sign-injection unit and the
// other PPU result producers. Results enter over a valid/ready handshake,
// are classified on entry (NaR, zero, negative, positive), are held in a
// small circular FIFO, and are offered in order to the core writeback port
// over a second valid/ready handshake.
//
// Parameters
//   N      posit width in bits
//   TAG_W  destination register tag width
//   DEPTH  FIFO entries (power of two, at least 2)
//
// Ports
//   clk_i         clock, all state updates on the rising edge
//   rst_ni        synchronous active-low reset
//   flush_i       synchronous clear of all buffered entries
//   in_valid_i    upstream result valid
//   in_ready_o    buffer can accept a result this cycle
//   in_result_i   posit result from the producing unit
//   in_tag_i      destination register tag
//   out_valid_o   head entry valid
//   out_ready_i   writeback port accepts the head entry
//   out_result_o  head entry posit (0 when out_valid_o is low)
//   out_tag_o     head entry tag (0 when out_valid_o is low)
//   out_class_o   head entry one-hot class {nar, zero, neg, pos}
//   count_o       number of occupied entries
// ---------------------------------------------------------------------------
module posit_result_wb #(
  parameter int N     = 32,
  parameter int TAG_W = 5,
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [N-1:0]             in_result_i,
  input  logic [TAG_W-1:0]         in_tag_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [N-1:0]             out_result_o,
  output logic [TAG_W-1:0]         out_tag_o,
  output logic [3:0]               out_class_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Payload storage is deliberately left without a reset: only the
  // pointers and the occupancy counter decide what is visible.
  logic [N-1:0]     result_q [DEPTH];
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [3:0]       class_q  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             push, pop;
  logic             is_zero, is_nar, is_neg, is_pos;
  logic [3:0]       in_class;

  // Classification of the incoming posit. NaR is the single pattern with
  // only the MSB set; every other pattern with the MSB set is negative.
  assign is_zero  = ~|in_result_i;
  assign is_nar   = in_result_i[N-1] & ~|in_result_i[N-2:0];
  assign is_neg   = in_result_i[N-1] & ~is_nar;
  assign is_pos   = ~in_result_i[N-1] & ~is_zero;
  assign in_class = {is_nar, is_zero, is_neg, is_pos};

  // Readiness only looks at occupancy, never at out_ready_i, so a full
  // buffer refuses a push even when the head is leaving this cycle.
  assign in_ready_o  = (count_q < FULL_CNT) & rst_ni;
  assign out_valid_o = (count_q != '0);
  assign count_o     = count_q;

  assign push = in_valid_i & in_ready_o;
  assign pop  = out_valid_o & out_ready_i;

  // Head entry is gated to zero while the buffer is empty so stale payload
  // never leaks onto the writeback port.
  assign out_result_o = out_valid_o ? result_q[rd_ptr_q] : '0;
  assign out_tag_o    = out_valid_o ? tag_q[rd_ptr_q]    : '0;
  assign out_class_o  = out_valid_o ? class_q[rd_ptr_q]  : '0;

  // Next-state for pointers and occupancy. Pointers are PTR_W bits wide and
  // DEPTH is a power of two, so natural overflow gives the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state. Reset outranks flush, and flush outranks any push or pop
  // presented in the same cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload write. A push that coincides with a flush is dropped, so its
  // data is not written either.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) begin
      result_q[wr_ptr_q] <= in_result_i;
      tag_q[wr_ptr_q]    <= in_tag_i;
      class_q[wr_ptr_q]  <= in_class;
    end
  end

endmodule
